// File: rtl/snn_1x1_grid_wrapper.sv
// Integrate-and-fire core: 256 axons drive NUM_NEURONS neurons through a binary crossbar.
// A tick walks each neuron through 256 integrate cycles and one fire cycle, in ascending order.
//
// state       | meaning
// S_IDLE      | waiting for a tick with both memories loaded
// S_INTEGRATE | one axon per cycle, adds the typed weight if active and connected
// S_FIRE      | leak, threshold test, reset/clamp, spike emit for the current neuron

module snn_1x1_grid_wrapper #(
  parameter int NUM_NEURONS = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         input_buffer_empty,
  input  logic [29:0]  packet_in,
  input  logic         param_winc,
  input  logic [367:0] param_wdata,
  output logic         param_wfull,
  input  logic         neuron_inst_winc,
  input  logic [1:0]   neuron_inst_wdata,
  output logic         neuron_inst_wfull,
  output logic [7:0]   packet_out,
  output logic         packet_out_valid,
  output logic         ren_to_input_buffer,
  output logic         token_controller_error,
  output logic         scheduler_error
);

  typedef enum logic [1:0] {S_IDLE, S_INTEGRATE, S_FIRE} state_t;

  state_t            r_state, w_state_nxt;
  logic [8:0]        r_param_wcnt, r_inst_wcnt;
  logic [367:0]      r_param_mem [256];
  logic [1:0]        r_inst_mem [256];
  logic signed [8:0] r_pot_mem [256];
  logic [255:0]      r_pending, r_active;
  logic [7:0]        r_neuron, r_axon;

  logic              w_full, w_ren, w_tick_go, w_last_axon, w_last_neuron;
  logic [367:0]      w_par;
  logic [255:0]      w_conn, w_pend_set;
  logic              w_conn_bit, w_int_en, w_mode, w_fire, w_below;
  logic signed [8:0] w_pot, w_weight, w_leak, w_pth, w_nth, w_rst_pot;
  logic signed [8:0] w_v, w_pot_int, w_pot_fire;
  logic signed [10:0] w_neg_lim;
  logic              w_unused;

  function automatic logic signed [10:0] ext(input logic signed [8:0] x);
    return {{2{x[8]}}, x};
  endfunction

  function automatic logic signed [8:0] sat9(input logic signed [10:0] x);
    if (x > 11'sd255) return 9'h0FF;
    else if (x < -11'sd256) return 9'h100;
    return x[8:0];
  endfunction

  assign param_wfull         = r_param_wcnt[8];
  assign neuron_inst_wfull   = r_inst_wcnt[8];
  assign w_full              = param_wfull & neuron_inst_wfull;
  assign w_ren               = ~input_buffer_empty & w_full;
  assign ren_to_input_buffer = w_ren;
  assign w_tick_go           = tick & w_full & (r_state == S_IDLE);
  assign w_last_axon         = (r_axon == 8'hFF);
  assign w_last_neuron       = (r_neuron == 8'(NUM_NEURONS - 1));
  assign w_pend_set          = w_ren ? (256'd1 << packet_in[7:0]) : '0;

  // Connection bit for axon a sits at word bit 367-a
  assign w_par      = r_param_mem[r_neuron];
  assign w_conn     = w_par[367:112];
  assign w_conn_bit = w_conn[8'd255 - r_axon];
  assign w_int_en   = (r_state == S_INTEGRATE) & w_conn_bit & r_active[r_axon];
  assign w_rst_pot  = w_par[102:94];
  assign w_leak     = w_par[57:49];
  assign w_pth      = w_par[48:40];
  assign w_nth      = w_par[39:31];
  assign w_mode     = w_par[30];
  assign w_pot      = r_pot_mem[r_neuron];
  assign w_unused   = ^{packet_in[29:8], w_par[29:12], w_par[3:0]};

  always_comb begin
    w_weight = w_par[93:85];
    case (r_inst_mem[r_axon])
      2'd1:    w_weight = w_par[84:76];
      2'd2:    w_weight = w_par[75:67];
      2'd3:    w_weight = w_par[66:58];
      default: ;
    endcase
  end

  assign w_pot_int = sat9(ext(w_pot) + ext(w_weight));
  assign w_v       = sat9(ext(w_pot) + ext(w_leak));
  assign w_fire    = (w_v >= w_pth);
  assign w_neg_lim = -ext(w_nth);
  assign w_below   = (ext(w_v) < w_neg_lim);

  always_comb begin
    w_pot_fire = w_v;
    if (w_fire) w_pot_fire = w_mode ? sat9(ext(w_v) - ext(w_pth)) : w_rst_pot;
    else if (w_below) w_pot_fire = sat9(w_neg_lim);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_tick_go) w_state_nxt = S_INTEGRATE;
      S_INTEGRATE: if (w_last_axon) w_state_nxt = S_FIRE;
      S_FIRE:      w_state_nxt = w_last_neuron ? S_IDLE : S_INTEGRATE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_param_wcnt           <= '0;
      r_inst_wcnt            <= '0;
      r_pending              <= '0;
      r_active               <= '0;
      r_neuron               <= '0;
      r_axon                 <= '0;
      packet_out             <= '0;
      packet_out_valid       <= 1'b0;
      token_controller_error <= 1'b0;
      scheduler_error        <= 1'b0;
    end else begin
      if (param_winc && !param_wfull) r_param_wcnt <= r_param_wcnt + 9'd1;
      if (neuron_inst_winc && !neuron_inst_wfull) r_inst_wcnt <= r_inst_wcnt + 9'd1;

      // A packet popped on the tick edge belongs to the next evaluation
      r_pending <= w_tick_go ? w_pend_set : (r_pending | w_pend_set);
      if (w_tick_go) r_active <= r_pending;
      else if (r_state == S_FIRE && w_last_neuron) r_active <= '0;

      if (w_tick_go) begin
        r_neuron <= '0;
        r_axon   <= '0;
      end else if (r_state == S_INTEGRATE) begin
        r_axon <= r_axon + 8'd1;
      end else if (r_state == S_FIRE) begin
        r_neuron <= r_neuron + 8'd1;
      end

      packet_out_valid <= (r_state == S_FIRE) & w_fire;
      if (r_state == S_FIRE && w_fire) packet_out <= w_par[11:4];

      if (tick && w_full && r_state != S_IDLE) token_controller_error <= 1'b1;
      if (tick && w_full && !input_buffer_empty) scheduler_error <= 1'b1;
    end
  end

  // Memories are not reset; loading and evaluation never overlap
  always_ff @(posedge clk) begin
    if (param_winc && !param_wfull) begin
      r_param_mem[r_param_wcnt[7:0]] <= param_wdata;
      r_pot_mem[r_param_wcnt[7:0]]   <= param_wdata[111:103];
    end else if (w_int_en) begin
      r_pot_mem[r_neuron] <= w_pot_int;
    end else if (r_state == S_FIRE) begin
      r_pot_mem[r_neuron] <= w_pot_fire;
    end
    if (neuron_inst_winc && !neuron_inst_wfull) r_inst_mem[r_inst_wcnt[7:0]] <= neuron_inst_wdata;
  end

endmodule

// File: tb/tb_snn_1x1_grid_wrapper.sv
// Bench for snn_1x1_grid_wrapper with 4 neurons: directed cases plus randomized ticks
// compared against a per-neuron arithmetic model of the spiking rules.

module tb_snn_1x1_grid_wrapper;
  localparam int NN   = 4;
  localparam int EVAL = 257 * NN;

  logic         clk = 1'b0, reset = 1'b1, tick = 1'b0, input_buffer_empty = 1'b1;
  logic [29:0]  packet_in = '0;
  logic         param_winc = 1'b0, neuron_inst_winc = 1'b0;
  logic [367:0] param_wdata = '0;
  logic [1:0]   neuron_inst_wdata = '0;
  logic         param_wfull, neuron_inst_wfull, packet_out_valid, ren_to_input_buffer;
  logic         token_controller_error, scheduler_error;
  logic [7:0]   packet_out;

  snn_1x1_grid_wrapper #(.NUM_NEURONS(NN)) dut (
    .clk(clk), .reset(reset), .tick(tick), .input_buffer_empty(input_buffer_empty),
    .packet_in(packet_in), .param_winc(param_winc), .param_wdata(param_wdata),
    .param_wfull(param_wfull), .neuron_inst_winc(neuron_inst_winc),
    .neuron_inst_wdata(neuron_inst_wdata), .neuron_inst_wfull(neuron_inst_wfull),
    .packet_out(packet_out), .packet_out_valid(packet_out_valid),
    .ren_to_input_buffer(ren_to_input_buffer),
    .token_controller_error(token_controller_error), .scheduler_error(scheduler_error));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int o_ax[$], o_cyc[$], e_ax[$], e_cyc[$];
  always @(negedge clk) begin
    if (packet_out_valid) begin
      o_ax.push_back(int'(packet_out));
      o_cyc.push_back(cyc);
    end
  end

  // reference model state
  bit [255:0]   m_conn [256];
  int           m_w [256][4];
  int           m_leak [256], m_pth [256], m_nth [256], m_rst [256], m_init [256], m_pot [256];
  bit           m_mode [256];
  bit [7:0]     m_oax [256];
  bit [1:0]     m_inst [256];
  logic [367:0] m_pword [256];
  bit [255:0]   m_pend;
  bit           m_full, m_terr, m_serr, m_any;
  int           m_last;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(int x);
    return (x > 255) ? 255 : (x < -256) ? -256 : x;
  endfunction

  function automatic int srand(int lo, int hi);
    return lo + int'($urandom_range(0, hi - lo));
  endfunction

  function automatic logic [367:0] pack(int n);
    logic [367:0] p = '0;
    for (int a = 0; a < 256; a++) p[367-a] = m_conn[n][a];
    p[111:103] = 9'(m_init[n]);
    p[102:94]  = 9'(m_rst[n]);
    p[93:85]   = 9'(m_w[n][0]);
    p[84:76]   = 9'(m_w[n][1]);
    p[75:67]   = 9'(m_w[n][2]);
    p[66:58]   = 9'(m_w[n][3]);
    p[57:49]   = 9'(m_leak[n]);
    p[48:40]   = 9'(m_pth[n]);
    p[39:31]   = 9'(m_nth[n]);
    p[30]      = m_mode[n];
    p[29:12]   = 18'($urandom);
    p[11:4]    = m_oax[n];
    p[3:0]     = 4'($urandom);
    return p;
  endfunction

  task automatic clear_cfg();
    for (int n = 0; n < 256; n++) begin
      m_conn[n] = '0;
      for (int k = 0; k < 4; k++) m_w[n][k] = 0;
      m_leak[n] = 0; m_pth[n] = 100; m_nth[n] = 100; m_rst[n] = 0; m_init[n] = 0;
      m_mode[n] = 1'b0; m_oax[n] = 8'(n + 16);
      m_inst[n] = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic rand_cfg();
    for (int n = 0; n < NN; n++) begin
      for (int a = 0; a < 256; a++)
        m_conn[n][a] = (a < 32) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
      for (int k = 0; k < 4; k++) m_w[n][k] = srand(-256, 255);
      m_leak[n] = srand(-20, 20); m_pth[n] = srand(-50, 150); m_nth[n] = srand(0, 200);
      m_rst[n] = srand(-50, 50); m_init[n] = srand(-100, 100);
      m_mode[n] = 1'($urandom_range(0, 1)); m_oax[n] = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    tick = 0; input_buffer_empty = 1; param_winc = 0; neuron_inst_winc = 0;
    reset = 1;
    #1;
    chk("rst_pkt", packet_out, 0);
    chk("rst_valid", packet_out_valid, 0);
    chk("rst_pfull", param_wfull, 0);
    chk("rst_ifull", neuron_inst_wfull, 0);
    chk("rst_terr", token_controller_error, 0);
    chk("rst_serr", scheduler_error, 0);
    chk("rst_ren", ren_to_input_buffer, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    m_pend = '0; m_full = 0; m_terr = 0; m_serr = 0; m_any = 0;
  endtask

  task automatic load_all();
    for (int i = 0; i < 256; i++) m_pword[i] = pack(i);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (i == 255) begin
        chk("pfull_pre", param_wfull, 0);
        chk("ifull_pre", neuron_inst_wfull, 0);
      end
      param_winc = 1; param_wdata = m_pword[i];
      neuron_inst_winc = 1; neuron_inst_wdata = m_inst[i];
    end
    @(negedge clk);
    chk("pfull", param_wfull, 1);
    chk("ifull", neuron_inst_wfull, 1);
    param_wdata = ~m_pword[0];
    neuron_inst_wdata = ~m_inst[0];
    @(negedge clk);
    param_winc = 0; neuron_inst_winc = 0;
    chk("p_ovf", dut.r_param_mem[0] == m_pword[0], 1);
    chk("i_ovf", dut.r_inst_mem[0], m_inst[0]);
    chk("pot_ovf", dut.r_pot_mem[0], m_init[0]);
    for (int i = 0; i < 256; i++) m_pot[i] = m_init[i];
    m_full = 1;
  endtask

  task automatic send_pkt(input int axon);
    @(negedge clk);
    input_buffer_empty = 0;
    packet_in = {22'($urandom), 8'(axon)};
    #1;
    chk("ren", ren_to_input_buffer, m_full);
    @(posedge clk);
    #1;
    input_buffer_empty = 1;
    if (m_full) m_pend[axon] = 1'b1;
  endtask

  task automatic model_tick();
    bit [255:0] act = m_pend;
    int v;
    m_pend = '0;
    for (int n = 0; n < NN; n++) begin
      for (int a = 0; a < 256; a++)
        if (act[a] && m_conn[n][a]) m_pot[n] = sat(m_pot[n] + m_w[n][m_inst[a]]);
      v = sat(m_pot[n] + m_leak[n]);
      if (v >= m_pth[n]) begin
        e_ax.push_back(int'(m_oax[n]));
        e_cyc.push_back(257 * (n + 1));
        m_pot[n] = m_mode[n] ? sat(v - m_pth[n]) : m_rst[n];
        m_any = 1; m_last = int'(m_oax[n]);
      end else if (v < -m_nth[n]) begin
        m_pot[n] = sat(-m_nth[n]);
      end else begin
        m_pot[n] = v;
      end
    end
  endtask

  task automatic run_tick(input bit busy_tick, input int sched_axon, input int n_busy);
    int t0;
    e_ax.delete(); e_cyc.delete(); o_ax.delete(); o_cyc.delete();
    @(negedge clk);
    tick = 1;
    if (sched_axon >= 0) begin
      input_buffer_empty = 0;
      packet_in = {22'($urandom), 8'(sched_axon)};
    end
    @(posedge clk);
    #1;
    t0 = cyc; tick = 0; input_buffer_empty = 1;
    model_tick();
    if (sched_axon >= 0) begin
      m_pend[sched_axon] = 1'b1;
      m_serr = 1'b1;
    end
    repeat (3) @(posedge clk);
    for (int k = 0; k < n_busy; k++) send_pkt(int'($urandom_range(0, 255)));
    if (busy_tick) begin
      @(negedge clk);
      tick = 1;
      @(posedge clk);
      #1;
      tick = 0;
      m_terr = 1;
    end
    while (cyc < t0 + EVAL + 3) @(posedge clk);
    #1;
    chk("nspk", o_ax.size(), e_ax.size());
    for (int i = 0; i < e_ax.size() && i < o_ax.size(); i++) begin
      chk($sformatf("spk%0d_axon", i), o_ax[i], e_ax[i]);
      chk($sformatf("spk%0d_cyc", i), o_cyc[i] - t0, e_cyc[i]);
    end
    for (int n = 0; n < NN; n++) chk($sformatf("pot%0d", n), dut.r_pot_mem[n], m_pot[n]);
    chk("valid_idle", packet_out_valid, 0);
    chk("terr", token_controller_error, m_terr);
    chk("serr", scheduler_error, m_serr);
    if (m_any) chk("pkt_hold", packet_out, m_last);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset, pre-load input blocked, single spike, quiet tick, busy tick
    do_reset();
    send_pkt(7);
    clear_cfg();
    m_conn[0][3] = 1; m_w[0][0] = 5; m_inst[3] = 0; m_pth[0] = 5; m_oax[0] = 8'h2A;
    load_all();
    send_pkt(3);
    run_tick(0, -1, 0);
    chk("s1_nspk", o_ax.size(), 1);
    if (o_ax.size() > 0) chk("s1_axon", o_ax[0], 'h2A);
    run_tick(0, -1, 0);
    chk("s2_nspk", o_ax.size(), 0);
    send_pkt(3);
    run_tick(1, -1, 0);
    chk("busy_nspk", o_ax.size(), 1);
    chk("busy_terr", token_controller_error, 1);

    // leak-driven firing on the third tick
    do_reset();
    clear_cfg();
    m_leak[0] = 1; m_pth[0] = 3;
    load_all();
    for (int t = 0; t < 3; t++) begin
      run_tick(0, -1, 0);
      chk($sformatf("leak_t%0d", t), o_ax.size(), (t == 2) ? 1 : 0);
    end

    // mode 1 subtracts the threshold
    do_reset();
    clear_cfg();
    m_leak[0] = 4; m_pth[0] = 3; m_mode[0] = 1;
    load_all();
    run_tick(0, -1, 0);
    chk("mode1_pot", dut.r_pot_mem[0], 1);

    // saturation and scheduler error
    do_reset();
    clear_cfg();
    for (int a = 10; a < 13; a++) begin
      m_conn[1][a] = 1;
      m_inst[a] = 2;
    end
    m_w[1][2] = 255; m_leak[1] = -10; m_pth[1] = 255;
    load_all();
    for (int a = 10; a < 13; a++) send_pkt(a);
    run_tick(0, 20, 0);
    chk("sat_pot", dut.r_pot_mem[1], 245);
    chk("sched_err", scheduler_error, 1);
    run_tick(0, -1, 0);

    // randomized configurations and traffic
    for (int r = 0; r < 2; r++) begin
      do_reset();
      clear_cfg();
      rand_cfg();
      load_all();
      for (int t = 0; t < 4; t++) begin
        int np = int'($urandom_range(0, 10));
        for (int k = 0; k < np; k++)
          send_pkt(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 31)));
        run_tick($urandom_range(0, 3) == 0,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1,
                 int'($urandom_range(0, 4)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/snn_1x1_grid_wrapper.md
# snn_1x1_grid_wrapper

Single-core, single-clock spiking-neural-network block: 256 axons feeding 256 integrate-and-fire neurons through a binary crossbar. Software preloads per-neuron parameters and per-axon type instructions through write ports. Input spike packets are popped from an external buffer, and a `tick` launches one sequential evaluation of all neurons. Each firing neuron emits an 8-bit output packet; the block sits between the host input buffer and the output spike collector.

## Interface
- `NUM_NEURONS`, 256: neurons evaluated per tick (1..256); entries 0..NUM_NEURONS-1 are used.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high.
- `tick` in 1: one-cycle pulse that starts an evaluation.
- `input_buffer_empty` in 1: low means `packet_in` is valid.
- `packet_in` in 30: input packet; bits [7:0] are the destination axon, bits [29:8] are ignored.
- `param_winc` in 1: parameter write strobe.
- `param_wdata` in 368: neuron parameter word.
- `param_wfull` out 1: all 256 parameter entries are loaded.
- `neuron_inst_winc` in 1: instruction write strobe.
- `neuron_inst_wdata` in 2: axon type (weight select).
- `neuron_inst_wfull` out 1: all 256 instruction entries are loaded.
- `packet_out` out 8: destination-axon field of the firing neuron.
- `packet_out_valid` out 1: one-cycle pulse per spike.
- `ren_to_input_buffer` out 1: pop strobe to the input buffer.
- `token_controller_error` out 1: sticky; set by a tick that arrives while busy.
- `scheduler_error` out 1: sticky; set by a tick that arrives while input is pending.

## Operation
- **Parameter word fields, MSB first**:
  - [367:112]: connections; bit 367-a set means axon a connects to this neuron.
  - [111:103]: initial potential.
  - [102:94]: reset potential.
  - [93:58]: weights w0..w3, 9 bits each (w0 at [93:85]).
  - [57:49]: leak.
  - [48:40]: positive threshold.
  - [39:31]: negative threshold.
  - [30]: reset mode.
  - [29:21]: dx. [20:12]: dy. [3:0]: tick field. dx, dy and the tick field are stored but unused.
  - [11:4]: output axon.
  - All 9-bit values are signed two's complement.
- **Loading**:
  - Each accepted `param_winc` writes entry `wcnt` and loads the potential array entry from [111:103]; `wcnt` then increments.
  - `param_wfull` goes high once `wcnt` reaches 256. Writes after that are ignored.
  - `neuron_inst_winc` works the same way, indexed by axon.
  - Both counters clear only on reset.
- **Input**:
  - `ren_to_input_buffer` = ~`input_buffer_empty` & `param_wfull` & `neuron_inst_wfull` (combinational).
  - On each edge with ren high, set `pending[packet_in[7:0]]`. Repeated axons are harmless (bitwise OR).
  - Input is accepted in every state, including BUSY.
- **Tick**:
  - Ignored unless both memories are full.
  - In IDLE: copy `pending` into `active`, clear `pending` (a packet popped on the same edge lands in `pending`), and enter BUSY at neuron 0, axon 0.
  - If `input_buffer_empty` is low at the tick edge, set `scheduler_error`.
  - A tick received in BUSY is ignored and sets `token_controller_error`.
- **FSM IDLE/INTEGRATE/FIRE**:
  - INTEGRATE, one axon a per cycle: if `active[a]` & conn[a], then pot = sat(pot + w[inst[a]]). After a=255, go to FIRE.
  - FIRE, one cycle:
    - v = sat(pot + leak).
    - If v >= positive threshold: spike; pot = reset potential when mode 0, else sat(v - positive threshold).
    - Else if v < -negative threshold: pot = -negative threshold.
    - Else pot = v.
    - Write pot back. If the spike fired, register `packet_out` = [11:4] and pulse `packet_out_valid`.
    - Next neuron → INTEGRATE; after neuron NUM_NEURONS-1 → IDLE, clearing `active`.
- **Saturation**: `sat()` clamps to [-256, 255].
- **Reset values**: all outputs 0; FSM IDLE; `pending`, `active` and both counters cleared. Memory contents are not reset.

## Timing
- Tick sampled at edge 0.
- Neuron n processes axon a at edge 257n+a+1 and evaluates FIRE at edge 257(n+1).
- `packet_out_valid` is high for exactly the cycle after that edge; `packet_out` holds its value until the next spike.
- Back in IDLE after edge 257·NUM_NEURONS: 65,792 cycles at the default.
- Spikes emerge in ascending neuron order, at most one every 257 cycles.
- Reset mid-evaluation aborts immediately; potentials keep their partially updated values.

## Test plan
- **Reset and empty state**: assert reset → all outputs 0, wfull flags 0. Packets presented before loading → `ren_to_input_buffer` stays 0.
- **Parameter and instruction loading**: write 256 parameter words → `param_wfull` is 1 after the 256th write edge, and a 257th write leaves entry 0 unchanged. Same check for instructions.
- **Single spike**: neuron 0 with conn[3]=1, w0=5, inst[3]=0, threshold 5, leak 0, output axon 0x2A, mode 0, reset potential 0. Send axon 3, then tick → `packet_out`=0x2A with one valid pulse after edge 257; no other spikes; a second tick with no input gives no spike.
- **Leak-driven firing**: leak +1, threshold 3, no input → fires on the 3rd tick only. With mode 1 and leak +4, the potential after firing is 1.
- **Busy tick**: tick during BUSY → `token_controller_error` is 1 and stays 1; the evaluation completes with a normal spike count.
- **Saturation and scheduler error**: weight 255 on 3 connected active axons → potential saturates at 255, no wrap. Tick while `input_buffer_empty`=0 → `scheduler_error` is 1.
